// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
//   Shared definitions for the UART frame parser: the parser state encoding,
//   the frame sync byte and the err_code values reported with frame_err.
// -----------------------------------------------------------------------------
package uart_frame_pkg;

    // Frame hunt / receive / replay sequence.
    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        CHECK,
        EMIT
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Reason codes reported on err_code alongside a frame_err pulse.
    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_BAD_CHK = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage : uart_frame_pkg

// File: rtl/uart_frame_buf.sv
// -----------------------------------------------------------------------------
// uart_frame_buf
//   Payload buffer: DEPTH x 8 bits, one write port, one read port with a
//   registered (synchronous) read.
// Ports
//   clk        system clock
//   wr_en_i    write strobe
//   wr_addr_i  write index
//   wr_data_i  write byte
//   rd_addr_i  read index, data appears on rd_data_o the following cycle
//   rd_data_o  registered read byte
// -----------------------------------------------------------------------------
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // NOTE: the storage array has no reset; a reset here would turn the RAM
    // into flops. The parser never replays an index it has not written.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule : uart_frame_buf

// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//   Consumes bytes from the UART receiver, hunts for frames of the form
//   SYNC(0xA5) LEN payload[LEN] CHK, buffers the payload, verifies length and
//   checksum (LEN + payload, mod 256) and replays a good payload as a
//   valid/ready byte stream. Bad frames are dropped with a frame_err pulse.
// Parameters
//   MAX_LEN       max payload bytes per frame (1..255), buffer depth
//   TIMEOUT_CLKS  max idle clocks between bytes inside a frame
// Ports
//   clk, rst            clock, synchronous active-high reset
//   byte_in/byte_valid  received byte and its 1-cycle strobe
//   out_data/out_valid  payload byte stream, held until out_ready
//   out_ready           sink accept
//   out_last            marks the final payload byte
//   frame_err/err_code  1-cycle discard pulse and its reason (code holds)
// Build option
//   UART_FRAME_STATS_EN adds good_cnt/bad_cnt saturating frame counters.
// -----------------------------------------------------------------------------
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 17360
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        frame_err,
    output logic [1:0]  err_code
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);

    localparam logic [7:0]    MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

    state_e        state_q, state_d;
    logic [LW-1:0] len_q,   len_d;
    logic [LW-1:0] idx_q,   idx_d;
    logic [7:0]    sum_q,   sum_d;
    logic [7:0]    chk_q,   chk_d;
    logic [TW-1:0] idle_q,  idle_d;
    logic          err_q,   err_d;
    logic [1:0]    code_q,  code_d;

    logic [LW-1:0] idx_inc;
    logic          in_frame;
    logic          timeout;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    assign idx_inc  = idx_q + LW'(1);
    assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign timeout  = in_frame && !byte_valid && (idle_q == TIMEOUT_LAST);

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (idx_q[AW-1:0]),
        .wr_data_i (byte_in),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        chk_d   = chk_q;
        err_d   = 1'b0;
        code_d  = code_q;
        wr_en   = 1'b0;
        rd_addr = idx_q[AW-1:0];
        idle_d  = (byte_valid || !in_frame) ? '0 : idle_q + TW'(1);

        unique case (state_q)
            HUNT: begin
                if (byte_valid && byte_in == SYNC_BYTE) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (byte_valid) begin
                    if (byte_in == 8'd0 || byte_in > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_LEN;
                        state_d = HUNT;
                    end else begin
                        len_d   = byte_in[LW-1:0];
                        sum_d   = byte_in;  // checksum covers LEN itself
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_valid) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + byte_in;
                    idx_d = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (byte_valid) begin
                    chk_d   = byte_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // Prefetch index 0 so the first byte is ready on entry to EMIT.
                idx_d   = '0;
                rd_addr = '0;
                if (chk_q == sum_q) begin
                    state_d = EMIT;
                    if (byte_valid) begin
                        err_d  = 1'b1;
                        code_d = ERR_OVERRUN;
                    end
                end else begin
                    err_d   = 1'b1;
                    code_d  = ERR_BAD_CHK;
                    state_d = HUNT;
                end
            end
            EMIT: begin
                if (byte_valid) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
                // On a handshake fetch the next index so back-to-back
                // transfers see fresh data; otherwise hold the current one.
                if (out_ready) begin
                    rd_addr = idx_inc[AW-1:0];
                    if (idx_inc == len_q) begin
                        state_d = HUNT;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = HUNT;
            idle_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            chk_q   <= '0;
            idle_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_OVERRUN;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            chk_q   <= chk_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign out_last  = out_valid && (idx_inc == len_q);
    // Gate the buffer output so stale RAM contents never reach the port.
    assign out_data  = out_valid ? rd_data : 8'h00;
    assign frame_err = err_q;
    assign err_code  = code_q;

`ifdef UART_FRAME_STATS_EN
    logic [15:0] good_q;
    logic [15:0] bad_q;
    logic        good_evt;

    assign good_evt = out_last && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            if (good_evt && good_q != 16'hFFFF) begin
                good_q <= good_q + 16'd1;
            end
            if (err_d && bad_q != 16'hFFFF) begin
                bad_q <= bad_q + 16'd1;
            end
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`endif

endmodule : uart_frame_parser

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
//   Directed bench for uart_frame_parser: good frames with and without sink
//   back-pressure, bad checksum, bad length, timeout and its boundary,
//   overrun during replay, and reset mid-frame. Expected payloads are written
//   out by hand from the frame bytes.
//   Define UART_FRAME_STATS_EN to also exercise good_cnt/bad_cnt.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int TO      = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_err;
    logic [1:0] err_code;
`ifdef UART_FRAME_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_err  (frame_err),
        .err_code   (err_code)
`ifdef UART_FRAME_STATS_EN
        ,
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Observation side: handshakes, error pulses and hold violations.
    logic [8:0] out_q[$];
    logic [1:0] err_q[$];
    int         stall_cycles = 0;
    int         stall_errs   = 0;
    logic       stall_prev   = 1'b0;
    logic [8:0] stall_word   = '0;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                stall_cycles++;
                if (!out_valid || {out_last, out_data} !== stall_word) stall_errs++;
            end
            if (out_valid && out_ready) out_q.push_back({out_last, out_data});
            if (frame_err) err_q.push_back(err_code);
            stall_prev = out_valid && !out_ready;
            stall_word = {out_last, out_data};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte is valid for exactly the current cycle; returns in the next one.
    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Wait (bounded) for n handshakes since base, optionally toggling ready.
    task automatic drain(input int base, input int n, input bit toggle);
        int cyc = 0;
        while (out_q.size() - base < n && cyc < 100) begin
            if (toggle) out_ready = ~out_ready;
            tick(1);
            cyc++;
        end
        out_ready = 1'b1;
        tick(3);
    endtask

    task automatic check_out(input string tag, input int base, input int n,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] e[3];
        e = '{b0, b1, b2};
        check({tag, "_count"}, out_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < out_q.size())
                check($sformatf("%s_byte%0d", tag, i), out_q[base + i], {(i == n - 1), e[i]});
        end
    endtask

    task automatic check_err(input string tag, input int base, input int n, input logic [1:0] code);
        check({tag, "_errs"}, err_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < err_q.size())
                check($sformatf("%s_code%0d", tag, i), err_q[base + i], code);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ob, eb, sb;

        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_err", frame_err, 1'b0);
        check("rst_code", err_code, 2'd0);

        // Good frame, sink always ready, exact replay timing.
        ob = out_q.size(); eb = err_q.size();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        check("good_check_cycle_valid", out_valid, 1'b0);
        tick(1);
        check("good_first_valid", out_valid, 1'b1);
        check("good_first_data", out_data, 8'h11);
        check("good_first_last", out_last, 1'b0);
        tick(2);
        check("good_last_data", out_data, 8'h33);
        check("good_last_flag", out_last, 1'b1);
        tick(1);
        check("good_after_valid", out_valid, 1'b0);
        tick(3);
        check_out("good", ob, 3, 8'h11, 8'h22, 8'h33);
        check_err("good", eb, 0, 2'd0);

        // Same frame with ready toggling every cycle.
        ob = out_q.size(); eb = err_q.size(); sb = stall_cycles;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        drain(ob, 3, 1'b1);
        check_out("toggle", ob, 3, 8'h11, 8'h22, 8'h33);
        check_err("toggle", eb, 0, 2'd0);
        check("toggle_stalled", (stall_cycles - sb) > 0, 1'b1);
        check("toggle_hold", stall_errs, 0);

        // Bad checksum, then a good 1-byte frame.
        ob = out_q.size(); eb = err_q.size();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'h00);
        tick(1);
        check("badchk_pulse", frame_err, 1'b1);
        check("badchk_valid", out_valid, 1'b0);
        tick(3);
        check_err("badchk", eb, 1, ERR_BAD_CHK);
        check_out("badchk", ob, 0, 8'h00, 8'h00, 8'h00);
        ob = out_q.size();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        drain(ob, 1, 1'b0);
        check_out("after_badchk", ob, 1, 8'h7E, 8'h00, 8'h00);

        // Zero and oversize length; the byte right after each is hunted.
        ob = out_q.size(); eb = err_q.size();
        send_byte(8'hA5); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h11);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        drain(ob, 1, 1'b0);
        check_err("badlen", eb, 2, ERR_BAD_LEN);
        check_out("badlen", ob, 1, 8'h7E, 8'h00, 8'h00);

        // Overrun while the replay is stalled.
        ob = out_q.size(); eb = err_q.size();
        out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        tick(1);
        check("ovr_valid", out_valid, 1'b1);
        send_byte(8'h55);
        check("ovr_pulse", frame_err, 1'b1);
        check("ovr_code", err_code, ERR_OVERRUN);
        check("ovr_hold_data", out_data, 8'h11);
        out_ready = 1'b1;
        drain(ob, 3, 1'b0);
        check_out("ovr", ob, 3, 8'h11, 8'h22, 8'h33);
        check_err("ovr", eb, 1, ERR_OVERRUN);
        check("ovr_hold", stall_errs, 0);

        // Timeout: no byte on the TO-th idle cycle after the last byte.
        eb = err_q.size();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        tick(TO - 1);
        check("to_before", frame_err, 1'b0);
        tick(1);
        check("to_pulse", frame_err, 1'b1);
        check("to_code", err_code, ERR_TIMEOUT);
        tick(3);
        check_err("to", eb, 1, ERR_TIMEOUT);

        // Byte landing on the timeout cycle wins.
        ob = out_q.size(); eb = err_q.size();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        tick(TO - 1);
        send_byte(8'h20);
        check("to_edge_no_pulse", frame_err, 1'b0);
        send_byte(8'h32);
        drain(ob, 2, 1'b0);
        check_out("to_edge", ob, 2, 8'h10, 8'h20, 8'h00);
        check_err("to_edge", eb, 0, 2'd0);

`ifdef UART_FRAME_STATS_EN
        check("stats_good", good_cnt, 16'd6);
        check("stats_bad", bad_cnt, 16'd5);
`endif

        // Reset mid-payload aborts silently.
        ob = out_q.size(); eb = err_q.size();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        do_reset();
        check("midrst_code", err_code, 2'd0);
        check("midrst_valid", out_valid, 1'b0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        drain(ob, 1, 1'b0);
        check_out("midrst", ob, 1, 8'h7E, 8'h00, 8'h00);
        check_err("midrst", eb, 0, 2'd0);
`ifdef UART_FRAME_STATS_EN
        check("stats_good_rst", good_cnt, 16'd1);
        check("stats_bad_rst", bad_cnt, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_frame_parser
